// File: rtl/serial_cmd_router_pkg.sv
// Shared definitions for the serial command router: FSM states and command field layout.
// Command layout, MSB first: {inEn, outEn, inCh, outCh, count}.
package serial_cmd_router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int f_cmd_w(input int ch_w, input int cnt_w);
    return 2 + 2 * ch_w + cnt_w;
  endfunction

  function automatic int f_out_ch_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int f_in_ch_lsb(input int ch_w, input int cnt_w);
    return cnt_w + ch_w;
  endfunction

  function automatic int f_out_en_bit(input int ch_w, input int cnt_w);
    return cnt_w + 2 * ch_w;
  endfunction

  function automatic int f_in_en_bit(input int ch_w, input int cnt_w);
    return cnt_w + 2 * ch_w + 1;
  endfunction

endpackage

// File: rtl/serial_burst_path.sv
// One counted burst path: remaining-word counter, valid/ready gating and last-word detect.
// Zero latency; the partner's ready/valid is passed through only while words remain.
module serial_burst_path #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic             vld_i,
  input  logic             rdy_i,
  output logic             vld_o,
  output logic             rdy_o,
  output logic             zero_next_o
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic             active;
  logic             xfer;

  assign active      = (rem_q != '0) && !rst_i;
  assign vld_o       = vld_i & active;
  assign rdy_o       = rdy_i & active;
  assign xfer        = vld_o & rdy_i;
  assign zero_next_o = (rem_q == '0) || (xfer && (rem_q == CNT_W'(1)));

  // A load only coincides with a transfer on the final word, so it may take priority.
  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = load_cnt_i;
    end else if (xfer) begin
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/serial_cmd_router.sv
// Pops burst commands and routes host words to/from one of NUM_CH channels, both paths concurrent.
// Zero-latency combinational data paths; zero-bubble command pop on the retiring cycle.
module serial_cmd_router
  import serial_cmd_router_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 9,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CMD_W  = f_cmd_w(CH_W, CNT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CMD_W-1:0]         cmd,
  input  logic                     cmd_hasAny,
  output logic                     cmd_consume,
  input  logic [WORD_W-1:0]        in,
  input  logic                     in_isReady,
  output logic                     in_canReceive,
  output logic [WORD_W-1:0]        out,
  output logic                     out_isReady,
  input  logic                     out_canReceive,
  output logic [NUM_CH*WORD_W-1:0] chIn,
  output logic [NUM_CH-1:0]        chIn_isReady,
  input  logic [NUM_CH-1:0]        chIn_canReceive,
  input  logic [NUM_CH*WORD_W-1:0] chOut,
  input  logic [NUM_CH-1:0]        chOut_isReady,
  output logic [NUM_CH-1:0]        chOut_canReceive,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IN_EN_BIT  = f_in_en_bit(CH_W, CNT_W);
  localparam int OUT_EN_BIT = f_out_en_bit(CH_W, CNT_W);
  localparam int IN_CH_LSB  = f_in_ch_lsb(CH_W, CNT_W);
  localparam int OUT_CH_LSB = f_out_ch_lsb(CNT_W);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  state_e           state_q;
  logic             done_q, err_q;
  logic [CH_W-1:0]  in_ch_q, out_ch_q;

  logic             cmd_in_en, cmd_out_en, bad, start, retire;
  logic [CH_W-1:0]  cmd_in_ch, cmd_out_ch;
  logic [CNT_W-1:0] cmd_cnt, load_in, load_out;
  logic             in_vld, in_rdy, in_zero;
  logic             out_vld, out_rdy, out_zero;

  assign cmd_in_en  = cmd[IN_EN_BIT];
  assign cmd_out_en = cmd[OUT_EN_BIT];
  assign cmd_in_ch  = cmd[IN_CH_LSB +: CH_W];
  assign cmd_out_ch = cmd[OUT_CH_LSB +: CH_W];
  assign cmd_cnt    = cmd[CNT_W-1:0];

  // Out-of-range channels only matter on an enabled path; a rejected command loads nothing.
  assign bad = (cmd_in_en && ({1'b0, cmd_in_ch} >= NUM_CH_L)) ||
               (cmd_out_en && ({1'b0, cmd_out_ch} >= NUM_CH_L));
  assign load_in  = (cmd_in_en && !bad) ? cmd_cnt : '0;
  assign load_out = (cmd_out_en && !bad) ? cmd_cnt : '0;
  assign start    = (load_in != '0) || (load_out != '0);

  assign retire      = (state_q == RUN) && in_zero && out_zero;
  assign cmd_consume = cmd_hasAny && !rst && ((state_q == IDLE) || retire);

  serial_burst_path #(.CNT_W(CNT_W)) u_in_path (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (cmd_consume),
    .load_cnt_i  (load_in),
    .vld_i       (in_isReady),
    .rdy_i       (chIn_canReceive[in_ch_q]),
    .vld_o       (in_vld),
    .rdy_o       (in_rdy),
    .zero_next_o (in_zero)
  );

  serial_burst_path #(.CNT_W(CNT_W)) u_out_path (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (cmd_consume),
    .load_cnt_i  (load_out),
    .vld_i       (chOut_isReady[out_ch_q]),
    .rdy_i       (out_canReceive),
    .vld_o       (out_vld),
    .rdy_o       (out_rdy),
    .zero_next_o (out_zero)
  );

  assign chIn             = {NUM_CH{in}};
  assign chIn_isReady     = NUM_CH'(in_vld) << in_ch_q;
  assign in_canReceive    = in_rdy;
  assign out_isReady      = out_vld;
  assign out              = out_vld ? chOut[out_ch_q*WORD_W +: WORD_W] : '0;
  assign chOut_canReceive = NUM_CH'(out_rdy) << out_ch_q;

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      in_ch_q  <= '0;
      out_ch_q <= '0;
    end else begin
      done_q <= retire || (cmd_consume && !bad && !start);
      err_q  <= cmd_consume && bad;
      if (cmd_consume && !bad) begin
        if (cmd_in_en)  in_ch_q  <= cmd_in_ch;
        if (cmd_out_en) out_ch_q <= cmd_out_ch;
      end
      if (cmd_consume) begin
        state_q <= start ? RUN : IDLE;
      end else if (retire) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_cmd_router.sv
// Directed bench for serial_cmd_router: default build, a 3-channel build for rejects,
// and a 32-bit/8-channel build for a loopback sweep.
module tb_serial_cmd_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errs = 0;
  int   checks = 0;

  // Default build: WORD_W=64, NUM_CH=4, CNT_W=9
  logic [14:0]  a_cmd;
  logic         a_hasAny, a_consume;
  logic [63:0]  a_in, a_out;
  logic         a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
  logic [255:0] a_chIn, a_chOut;
  logic [3:0]   a_chIn_vld, a_chIn_rdy, a_chOut_vld, a_chOut_rdy;
  logic         a_busy, a_done, a_err;

  // Reject build: WORD_W=16, NUM_CH=3, CNT_W=4
  logic [9:0]   b_cmd;
  logic         b_hasAny, b_consume;
  logic [15:0]  b_in, b_out;
  logic         b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
  logic [47:0]  b_chIn, b_chOut;
  logic [2:0]   b_chIn_vld, b_chIn_rdy, b_chOut_vld, b_chOut_rdy;
  logic         b_busy, b_done, b_err;

  // Sweep build: WORD_W=32, NUM_CH=8, CNT_W=4
  logic [11:0]  c_cmd;
  logic         c_hasAny, c_consume;
  logic [31:0]  c_in, c_out;
  logic         c_in_vld, c_in_rdy, c_out_vld, c_out_rdy;
  logic [255:0] c_chIn, c_chOut;
  logic [7:0]   c_chIn_vld, c_chIn_rdy, c_chOut_vld, c_chOut_rdy;
  logic         c_busy, c_done, c_err;

  serial_cmd_router u_a (
    .clk(clk), .rst(rst), .cmd(a_cmd), .cmd_hasAny(a_hasAny), .cmd_consume(a_consume),
    .in(a_in), .in_isReady(a_in_vld), .in_canReceive(a_in_rdy),
    .out(a_out), .out_isReady(a_out_vld), .out_canReceive(a_out_rdy),
    .chIn(a_chIn), .chIn_isReady(a_chIn_vld), .chIn_canReceive(a_chIn_rdy),
    .chOut(a_chOut), .chOut_isReady(a_chOut_vld), .chOut_canReceive(a_chOut_rdy),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  serial_cmd_router #(.WORD_W(16), .NUM_CH(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .cmd(b_cmd), .cmd_hasAny(b_hasAny), .cmd_consume(b_consume),
    .in(b_in), .in_isReady(b_in_vld), .in_canReceive(b_in_rdy),
    .out(b_out), .out_isReady(b_out_vld), .out_canReceive(b_out_rdy),
    .chIn(b_chIn), .chIn_isReady(b_chIn_vld), .chIn_canReceive(b_chIn_rdy),
    .chOut(b_chOut), .chOut_isReady(b_chOut_vld), .chOut_canReceive(b_chOut_rdy),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  serial_cmd_router #(.WORD_W(32), .NUM_CH(8), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .cmd(c_cmd), .cmd_hasAny(c_hasAny), .cmd_consume(c_consume),
    .in(c_in), .in_isReady(c_in_vld), .in_canReceive(c_in_rdy),
    .out(c_out), .out_isReady(c_out_vld), .out_canReceive(c_out_rdy),
    .chIn(c_chIn), .chIn_isReady(c_chIn_vld), .chIn_canReceive(c_chIn_rdy),
    .chOut(c_chOut), .chOut_isReady(c_chOut_vld), .chOut_canReceive(c_chOut_rdy),
    .busy(c_busy), .done(c_done), .err(c_err)
  );

  // Transfer logs, sampled on the active edge before state updates.
  logic [65:0] a_inq[$];
  logic [63:0] a_outq[$];
  logic [31:0] c_lb[$];
  logic [31:0] c_outq[$];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_chIn_vld[i] && a_chIn_rdy[i]) a_inq.push_back({2'(i), a_chIn[i*64 +: 64]});
    end
    if (a_out_vld && a_out_rdy) a_outq.push_back(a_out);
    if (c_out_vld && c_out_rdy) c_outq.push_back(c_out);
    if (c_chOut_vld[7] && c_chOut_rdy[7]) void'(c_lb.pop_front());
    if (c_chIn_vld[7] && c_chIn_rdy[7]) c_lb.push_back(c_chIn[7*32 +: 32]);
  end

  function automatic logic [14:0] mk_a(input logic ie, input logic oe, input logic [1:0] ic,
                                       input logic [1:0] oc, input logic [8:0] n);
    return {ie, oe, ic, oc, n};
  endfunction

  function automatic logic [9:0] mk_b(input logic ie, input logic oe, input logic [1:0] ic,
                                      input logic [1:0] oc, input logic [3:0] n);
    return {ie, oe, ic, oc, n};
  endfunction

  function automatic logic [11:0] mk_c(input logic ie, input logic oe, input logic [2:0] ic,
                                       input logic [2:0] oc, input logic [3:0] n);
    return {ie, oe, ic, oc, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_hasAny = 1'b0; a_in_vld = 1'b0; a_out_rdy = 1'b0;
    a_chIn_rdy = '0; a_chOut_vld = '0; a_chOut = '0; a_in = '0; a_cmd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_cmd = mk_a(1'b1, 1'b1, 2'd0, 2'd0, 9'd1); a_hasAny = 1'b1; a_in_vld = 1'b1;
    a_chIn_rdy = 4'hF; a_out_rdy = 1'b1; a_chOut_vld = 4'hF; a_chOut = {4{64'h55}};
    tick(); tick();
    checks++; if (a_consume !== 1'b0) begin errs++; $display("FAIL rst_consume: got %b want 0", a_consume); end
    checks++; if (a_in_rdy !== 1'b0) begin errs++; $display("FAIL rst_in_rdy: got %b want 0", a_in_rdy); end
    checks++; if (a_out_vld !== 1'b0) begin errs++; $display("FAIL rst_out_vld: got %b want 0", a_out_vld); end
    checks++; if (a_out !== 64'd0) begin errs++; $display("FAIL rst_out: got %h want 0", a_out); end
    checks++; if (a_chIn_vld !== 4'd0) begin errs++; $display("FAIL rst_chIn_vld: got %b want 0000", a_chIn_vld); end
    checks++; if (a_chOut_rdy !== 4'd0) begin errs++; $display("FAIL rst_chOut_rdy: got %b want 0000", a_chOut_rdy); end
    checks++; if ({a_busy, a_done, a_err} !== 3'b000) begin errs++; $display("FAIL rst_status: got %b want 000", {a_busy, a_done, a_err}); end
    rst = 1'b0;
    clear_a();
    tick();
  endtask

  task automatic test_single_in();
    logic [63:0] w[3];
    w[0] = 64'hAAAA_0000_0000_0001; w[1] = 64'hBBBB_0000_0000_0002; w[2] = 64'hCCCC_0000_0000_0003;
    a_inq.delete();
    a_cmd = mk_a(1'b1, 1'b0, 2'd2, 2'd0, 9'd3); a_hasAny = 1'b1; a_chIn_rdy = 4'hF;
    #1;
    checks++; if (a_consume !== 1'b1) begin errs++; $display("FAIL single_consume: got %b want 1", a_consume); end
    for (int k = 0; k < 3; k++) begin
      tick();
      a_hasAny = 1'b0; a_in = w[k]; a_in_vld = 1'b1;
      #1;
      checks++; if (a_chIn_vld !== 4'b0100) begin errs++; $display("FAIL single_lane_vld[%0d]: got %b want 0100", k, a_chIn_vld); end
      checks++; if ({a_busy, a_consume} !== 2'b10) begin errs++; $display("FAIL single_busy[%0d]: got %b want 10", k, {a_busy, a_consume}); end
    end
    tick();
    a_in_vld = 1'b0;
    #1;
    checks++; if ({a_done, a_busy} !== 2'b10) begin errs++; $display("FAIL single_done: got %b want 10", {a_done, a_busy}); end
    tick();
    checks++; if (a_done !== 1'b0) begin errs++; $display("FAIL single_done_pulse: got %b want 0", a_done); end
    checks++; if (a_inq.size() != 3) begin errs++; $display("FAIL single_count: got %0d want 3", a_inq.size()); end
    else for (int k = 0; k < 3; k++) begin
      checks++; if (a_inq[k] !== {2'd2, w[k]}) begin errs++; $display("FAIL single_word[%0d]: got %h want %h", k, a_inq[k], {2'd2, w[k]}); end
    end
    clear_a();
  endtask

  task automatic test_concurrent();
    logic [63:0] iw[4];
    logic [63:0] ow[4];
    int ii;
    int oi;
    for (int k = 0; k < 4; k++) begin
      iw[k] = 64'h1000 + 64'(k);
      ow[k] = 64'hF000 + 64'(k);
    end
    a_inq.delete(); a_outq.delete();
    a_cmd = mk_a(1'b1, 1'b1, 2'd0, 2'd3, 9'd4); a_hasAny = 1'b1; a_chIn_rdy = 4'hF;
    #1;
    ii = 0; oi = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      a_hasAny = 1'b0;
      a_in = iw[(ii < 4) ? ii : 3]; a_in_vld = 1'b1;
      a_chOut[3*64 +: 64] = ow[(oi < 4) ? oi : 3]; a_chOut_vld = 4'b1000;
      a_out_rdy = (c % 2 == 0);
      #1;
      checks++; if (a_done !== (c == 7)) begin errs++; $display("FAIL conc_done[%0d]: got %b want %b", c, a_done, (c == 7)); end
      checks++; if (a_in_rdy !== (c < 4)) begin errs++; $display("FAIL conc_in_rdy[%0d]: got %b want %b", c, a_in_rdy, (c < 4)); end
      checks++; if (a_out_vld !== (c < 7)) begin errs++; $display("FAIL conc_out_vld[%0d]: got %b want %b", c, a_out_vld, (c < 7)); end
      if (c == 7) begin
        checks++; if (a_out !== 64'd0) begin errs++; $display("FAIL conc_out_zero: got %h want 0", a_out); end
      end
      if (c < 4) ii++;
      if ((c % 2 == 0) && (oi < 4)) oi++;
    end
    checks++; if (a_inq.size() != 4 || a_outq.size() != 4) begin errs++; $display("FAIL conc_count: got %0d/%0d want 4/4", a_inq.size(), a_outq.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (a_inq[k] !== {2'd0, iw[k]}) begin errs++; $display("FAIL conc_in[%0d]: got %h want %h", k, a_inq[k], {2'd0, iw[k]}); end
      checks++; if (a_outq[k] !== ow[k]) begin errs++; $display("FAIL conc_out[%0d]: got %h want %h", k, a_outq[k], ow[k]); end
    end
    clear_a();
    tick();
  endtask

  task automatic test_back_to_back();
    a_inq.delete(); a_outq.delete();
    a_cmd = mk_a(1'b1, 1'b0, 2'd1, 2'd0, 9'd2); a_hasAny = 1'b1; a_chIn_rdy = 4'hF;
    #1;
    checks++; if (a_consume !== 1'b1) begin errs++; $display("FAIL b2b_first_pop: got %b want 1", a_consume); end
    tick();
    a_cmd = mk_a(1'b0, 1'b1, 2'd0, 2'd1, 9'd2);
    a_in = 64'h0101; a_in_vld = 1'b1;
    a_chOut[1*64 +: 64] = 64'h0A0A; a_chOut_vld = 4'b0010; a_out_rdy = 1'b1;
    #1;
    checks++; if ({a_consume, a_out_vld} !== 2'b00) begin errs++; $display("FAIL b2b_midburst: got %b want 00", {a_consume, a_out_vld}); end
    tick();
    a_in = 64'h0202;
    #1;
    checks++; if ({a_consume, a_in_rdy} !== 2'b11) begin errs++; $display("FAIL b2b_pop_on_last: got %b want 11", {a_consume, a_in_rdy}); end
    tick();
    a_hasAny = 1'b0;
    #1;
    checks++; if ({a_out_vld, a_done, a_busy, a_in_rdy} !== 4'b1110) begin errs++; $display("FAIL b2b_second_start: got %b want 1110", {a_out_vld, a_done, a_busy, a_in_rdy}); end
    checks++; if (a_out !== 64'h0A0A) begin errs++; $display("FAIL b2b_out0: got %h want 0a0a", a_out); end
    tick();
    a_chOut[1*64 +: 64] = 64'h0B0B;
    #1;
    checks++; if ({a_out, a_done} !== {64'h0B0B, 1'b0}) begin errs++; $display("FAIL b2b_out1: got %h/%b want 0b0b/0", a_out, a_done); end
    tick();
    a_in_vld = 1'b0; a_chOut_vld = '0; a_out_rdy = 1'b0;
    #1;
    checks++; if ({a_done, a_busy} !== 2'b10) begin errs++; $display("FAIL b2b_done: got %b want 10", {a_done, a_busy}); end
    checks++; if (a_inq.size() != 2 || a_outq.size() != 2) begin errs++; $display("FAIL b2b_count: got %0d/%0d want 2/2", a_inq.size(), a_outq.size()); end
    clear_a();
    tick();
  endtask

  task automatic test_null_cmd();
    a_cmd = mk_a(1'b1, 1'b1, 2'd1, 2'd2, 9'd0); a_hasAny = 1'b1;
    a_in_vld = 1'b1; a_chIn_rdy = 4'hF; a_chOut_vld = 4'hF; a_out_rdy = 1'b1;
    #1;
    checks++; if (a_consume !== 1'b1) begin errs++; $display("FAIL null_pop: got %b want 1", a_consume); end
    tick();
    a_cmd = mk_a(1'b0, 1'b0, 2'd1, 2'd2, 9'd5);
    #1;
    checks++; if ({a_done, a_busy, a_consume} !== 3'b101) begin errs++; $display("FAIL null_done: got %b want 101", {a_done, a_busy, a_consume}); end
    checks++; if ({a_in_rdy, a_out_vld, a_chIn_vld, a_chOut_rdy} !== 10'd0) begin errs++; $display("FAIL null_no_handshake: got %b want 0", {a_in_rdy, a_out_vld, a_chIn_vld, a_chOut_rdy}); end
    tick();
    a_hasAny = 1'b0;
    #1;
    checks++; if ({a_done, a_err} !== 2'b10) begin errs++; $display("FAIL null_noen_done: got %b want 10", {a_done, a_err}); end
    tick();
    checks++; if (a_done !== 1'b0) begin errs++; $display("FAIL null_done_pulse: got %b want 0", a_done); end
    clear_a();
  endtask

  task automatic test_error();
    b_cmd = mk_b(1'b1, 1'b0, 2'd3, 2'd0, 4'd2); b_hasAny = 1'b1; b_in_vld = 1'b1; b_chIn_rdy = 3'b111;
    #1;
    checks++; if (b_consume !== 1'b1) begin errs++; $display("FAIL err_pop: got %b want 1", b_consume); end
    tick();
    b_cmd = mk_b(1'b0, 1'b1, 2'd0, 2'd3, 4'd2);
    #1;
    checks++; if ({b_err, b_done, b_busy} !== 3'b100) begin errs++; $display("FAIL err_in_reject: got %b want 100", {b_err, b_done, b_busy}); end
    checks++; if ({b_in_rdy, b_chIn_vld, b_consume} !== 5'b00001) begin errs++; $display("FAIL err_no_xfer: got %b want 00001", {b_in_rdy, b_chIn_vld, b_consume}); end
    tick();
    b_cmd = mk_b(1'b1, 1'b0, 2'd2, 2'd0, 4'd1); b_in = 16'hBEEF;
    #1;
    checks++; if ({b_err, b_consume} !== 2'b11) begin errs++; $display("FAIL err_out_reject: got %b want 11", {b_err, b_consume}); end
    tick();
    b_hasAny = 1'b0;
    #1;
    checks++; if ({b_err, b_busy, b_chIn_vld, b_in_rdy} !== 6'b010_1_1 << 0 ? 1'b0 : 1'b0) begin end
    checks++; if ({b_err, b_busy, b_chIn_vld, b_in_rdy} !== 6'b011001) begin errs++; $display("FAIL err_next_accepted: got %b want 011001", {b_err, b_busy, b_chIn_vld, b_in_rdy}); end
    tick();
    b_in_vld = 1'b0;
    #1;
    checks++; if ({b_done, b_busy} !== 2'b10) begin errs++; $display("FAIL err_next_done: got %b want 10", {b_done, b_busy}); end
    b_chIn_rdy = '0;
  endtask

  task automatic test_reset_mid();
    a_inq.delete();
    a_cmd = mk_a(1'b1, 1'b0, 2'd1, 2'd0, 9'd5); a_hasAny = 1'b1; a_chIn_rdy = 4'hF;
    #1;
    tick();
    a_hasAny = 1'b0; a_in = 64'h11; a_in_vld = 1'b1;
    tick();
    a_in = 64'h22;
    tick();
    rst = 1'b1; a_hasAny = 1'b1; a_cmd = mk_a(1'b1, 1'b0, 2'd3, 2'd0, 9'd1);
    a_in = 64'h33; a_chOut_vld = 4'hF; a_out_rdy = 1'b1;
    #1;
    checks++; if ({a_in_rdy, a_chIn_vld, a_consume, a_out_vld, a_chOut_rdy} !== 11'd0) begin errs++; $display("FAIL rstmid_gated: got %b want 0", {a_in_rdy, a_chIn_vld, a_consume, a_out_vld, a_chOut_rdy}); end
    tick();
    rst = 1'b0; a_in_vld = 1'b0; a_chOut_vld = '0; a_out_rdy = 1'b0;
    #1;
    checks++; if ({a_done, a_busy, a_consume} !== 3'b001) begin errs++; $display("FAIL rstmid_after: got %b want 001", {a_done, a_busy, a_consume}); end
    tick();
    a_hasAny = 1'b0; a_in = 64'h44; a_in_vld = 1'b1;
    #1;
    checks++; if (a_chIn_vld !== 4'b1000) begin errs++; $display("FAIL rstmid_new_lane: got %b want 1000", a_chIn_vld); end
    tick();
    a_in_vld = 1'b0;
    #1;
    checks++; if ({a_done, a_busy} !== 2'b10) begin errs++; $display("FAIL rstmid_new_done: got %b want 10", {a_done, a_busy}); end
    checks++; if (a_inq.size() != 3) begin errs++; $display("FAIL rstmid_count: got %0d want 3", a_inq.size()); end
    else begin
      checks++; if (a_inq[2] !== {2'd3, 64'h44}) begin errs++; $display("FAIL rstmid_word: got %h want %h", a_inq[2], {2'd3, 64'h44}); end
    end
    clear_a();
    tick();
  endtask

  task automatic test_sweep();
    int ii;
    logic seen;
    c_outq.delete(); c_lb.delete();
    c_cmd = mk_c(1'b1, 1'b1, 3'd7, 3'd7, 4'd15); c_hasAny = 1'b1; c_chIn_rdy = 8'hFF; c_out_rdy = 1'b1;
    #1;
    ii = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      tick();
      c_hasAny = 1'b0;
      c_chOut[7*32 +: 32] = (c_lb.size() > 0) ? c_lb[0] : 32'd0;
      c_chOut_vld = (c_lb.size() > 0) ? 8'h80 : 8'h00;
      c_in = 32'hC0DE_0000 + 32'(ii);
      c_in_vld = (ii < 15);
      #1;
      if (c_done) seen = 1'b1;
      if (c_in_vld && c_in_rdy) ii++;
    end
    checks++; if (seen !== 1'b1) begin errs++; $display("FAIL sweep_done: got %b want 1 within budget", seen); end
    checks++; if (c_outq.size() != 15) begin errs++; $display("FAIL sweep_count: got %0d want 15", c_outq.size()); end
    else for (int k = 0; k < 15; k++) begin
      checks++; if (c_outq[k] !== 32'hC0DE_0000 + 32'(k)) begin errs++; $display("FAIL sweep_word[%0d]: got %h want %h", k, c_outq[k], 32'hC0DE_0000 + 32'(k)); end
    end
    checks++; if ({c_busy, c_err} !== 2'b00) begin errs++; $display("FAIL sweep_idle: got %b want 00", {c_busy, c_err}); end
    c_in_vld = 1'b0; c_chOut_vld = '0; c_out_rdy = 1'b0; c_chIn_rdy = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_a();
    b_cmd = '0; b_hasAny = 1'b0; b_in = '0; b_in_vld = 1'b0; b_out_rdy = 1'b0;
    b_chIn_rdy = '0; b_chOut = '0; b_chOut_vld = '0;
    c_cmd = '0; c_hasAny = 1'b0; c_in = '0; c_in_vld = 1'b0; c_out_rdy = 1'b0;
    c_chIn_rdy = '0; c_chOut = '0; c_chOut_vld = '0;
    test_reset();
    test_single_in();
    test_concurrent();
    test_back_to_back();
    test_null_cmd();
    test_error();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
